// File: rtl/sdram_pixel_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pixel_packer_pkg
//  Description : Shared definitions for the camera-side SDRAM pixel packer:
//                exposure-tag encodings, FSM state encoding, frame geometry,
//                default frame base addresses and the exposure-advance helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pixel_packer_pkg;

  localparam int          c_PIXEL_W      = 16;
  localparam int          c_WORD_W       = 128;
  localparam int          c_PIX_PER_WORD = c_WORD_W / c_PIXEL_W;
  localparam int          c_FRAME_WORDS  = 38400;   // 640*480*16/128
  localparam int          c_ADDR_W       = 24;
  localparam logic [23:0] c_BASE_HIGH    = 24'h000000;
  localparam logic [23:0] c_BASE_MID     = 24'h010000;
  localparam logic [23:0] c_BASE_LOW     = 24'h020000;

  // Exposure tag as carried on wr_exp / exposure
  typedef enum logic [1:0] {
    EXP_HIGH = 2'd0,
    EXP_MID  = 2'd1,
    EXP_LOW  = 2'd2
  } exp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Exposure bracketing order HIGH -> MID -> LOW -> HIGH
  function automatic exp_e next_exp(input exp_e e);
    case (e)
      EXP_HIGH: next_exp = EXP_MID;
      EXP_MID:  next_exp = EXP_LOW;
      default:  next_exp = EXP_HIGH;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_pixel_packer_pack_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : pack_fifo2
//  Description : Two-entry synchronous FIFO for packed SDRAM words. A push
//                while full is accepted only if a pop happens in the same
//                cycle; o_push_ok tells the caller whether the push landed.
//  Ports       : clk_25M, rst_n_25M (async active-low)
//                i_push/i_data   write side
//                i_pop           read side (ignored when empty)
//                o_data          head entry (registered storage)
//                o_full/o_empty  occupancy flags
//                o_push_ok       push accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module pack_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk_25M,
  input  logic              rst_n_25M,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_push_ok
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign o_empty   = (r_count == 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign w_pop     = i_pop && !o_empty;
  // When full, the slot being vacated by the pop is the one the write lands in
  assign o_push_ok = i_push && (!o_full || w_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (o_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({o_push_ok, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pixel_packer
//  Description : Packs camera pixels into SDRAM words (pixel 0 in the low
//                lane), tags each word with base(exposure)+word index and the
//                exposure tag, and queues it in a 2-entry output FIFO. The
//                exposure advances HIGH->MID->LOW at the end of each frame.
//  Ports       : clk_25M, rst_n_25M      pixel clock, async active-low reset
//                pixel_in/pixel_valid    pixel stream
//                frame_start             frame sync pulse
//                err_clr                 clears overflow / frame_err
//                wr_data/wr_addr/wr_exp  head word, address and tag
//                wr_valid/wr_ready       output handshake
//                exposure                exposure of the frame being captured
//                frame_done              pulse after the last word is packed
//                overflow/frame_err      sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_pixel_packer
  import sdram_pixel_packer_pkg::*;
#(
  parameter int                PIXEL_W     = c_PIXEL_W,
  parameter int                WORD_W      = c_WORD_W,
  parameter int                FRAME_WORDS = c_FRAME_WORDS,
  parameter int                ADDR_W      = c_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_HIGH   = ADDR_W'(c_BASE_HIGH),
  parameter logic [ADDR_W-1:0] BASE_MID    = ADDR_W'(c_BASE_MID),
  parameter logic [ADDR_W-1:0] BASE_LOW    = ADDR_W'(c_BASE_LOW)
) (
  input  logic               clk_25M,
  input  logic               rst_n_25M,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic               err_clr,
  output logic [WORD_W-1:0]  wr_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [1:0]         wr_exp,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [1:0]         exposure,
  output logic               frame_done,
  output logic               overflow,
  output logic               frame_err
);

  localparam int c_PPW     = WORD_W / PIXEL_W;
  localparam int c_LANE_W  = $clog2(c_PPW);
  // One extra count so the increment on the last word of a frame cannot wrap
  localparam int c_WCNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int c_ENTRY_W = 2 + ADDR_W + WORD_W;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_PPW - 1);
  localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(FRAME_WORDS - 1);

  state_e                r_state;
  exp_e                  r_exp;
  logic [c_LANE_W-1:0]   r_lane_cnt;
  logic [c_WCNT_W-1:0]   r_word_cnt;
  logic                  r_frame_done;
  logic                  r_overflow;
  logic                  r_frame_err;

  logic                  w_pix_we;
  logic [c_LANE_W-1:0]   w_lane_idx;
  logic                  w_push;
  logic [WORD_W-1:0]     w_word;
  logic [ADDR_W-1:0]     w_base;
  logic [ADDR_W-1:0]     w_addr;
  logic [c_ENTRY_W-1:0]  w_entry_in;
  logic [c_ENTRY_W-1:0]  w_entry_out;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_pop;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_ferr_set;

  // A pixel is captured in ACTIVE, or in any state when it rides along with
  // frame_start (it then becomes lane 0 of the new frame).
  assign w_pix_we   = pixel_valid && (frame_start || (r_state == ST_ACTIVE));
  assign w_lane_idx = frame_start ? '0 : r_lane_cnt;
  assign w_push     = pixel_valid && !frame_start && (r_state == ST_ACTIVE)
                      && (r_lane_cnt == c_LAST_LANE);

  // Lanes 0..N-2 are held in registers; the last lane is taken straight from
  // pixel_in so the word is complete on the cycle of its final pixel.
  for (genvar g = 0; g < c_PPW - 1; g++) begin : g_lane
    logic [PIXEL_W-1:0] r_pix;
    always_ff @(posedge clk_25M or negedge rst_n_25M) begin
      if (!rst_n_25M)
        r_pix <= '0;
      else if (w_pix_we && (w_lane_idx == c_LANE_W'(g)))
        r_pix <= pixel_in;
    end
    assign w_word[g*PIXEL_W +: PIXEL_W] = r_pix;
  end
  assign w_word[WORD_W-1 -: PIXEL_W] = pixel_in;

  always_comb begin
    w_base = BASE_HIGH;
    case (r_exp)
      EXP_MID: w_base = BASE_MID;
      EXP_LOW: w_base = BASE_LOW;
      default: w_base = BASE_HIGH;
    endcase
  end

  assign w_addr     = w_base + ADDR_W'(r_word_cnt);
  assign w_entry_in = {r_exp, w_addr, w_word};
  assign w_fifo_pop = wr_ready && !w_fifo_empty;
  assign w_ovf_set  = w_push && !w_push_ok;
  assign w_ferr_set = frame_start && (r_state == ST_ACTIVE);

  pack_fifo2 #(
    .DATA_W (c_ENTRY_W)
  ) u_fifo (
    .clk_25M   (clk_25M),
    .rst_n_25M (rst_n_25M),
    .i_push    (w_push),
    .i_data    (w_entry_in),
    .i_pop     (w_fifo_pop),
    .o_data    (w_entry_out),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_push_ok (w_push_ok)
  );

  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      r_state      <= ST_IDLE;
      r_exp        <= EXP_HIGH;
      r_lane_cnt   <= '0;
      r_word_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state    <= ST_ACTIVE;
            r_word_cnt <= '0;
            r_lane_cnt <= pixel_valid ? c_LANE_W'(1) : '0;
          end
        end
        ST_ACTIVE: begin
          if (frame_start) begin
            // Resync: drop the partial word, restart addressing, same exposure
            r_word_cnt <= '0;
            r_lane_cnt <= pixel_valid ? c_LANE_W'(1) : '0;
          end else if (pixel_valid) begin
            if (r_lane_cnt == c_LAST_LANE) begin
              // Counts even a dropped word so later addresses stay aligned
              r_lane_cnt <= '0;
              r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
              if (r_word_cnt == c_LAST_WORD) begin
                r_state      <= ST_DONE;
                r_frame_done <= 1'b1;
              end
            end else begin
              r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_exp <= next_exp(r_exp);
          if (frame_start) begin
            r_state    <= ST_ACTIVE;
            r_word_cnt <= '0;
            r_lane_cnt <= pixel_valid ? c_LANE_W'(1) : '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Sticky flags: a set event beats err_clr in the same cycle
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (err_clr)   r_overflow <= 1'b0;
      if (w_ferr_set)     r_frame_err <= 1'b1;
      else if (err_clr)   r_frame_err <= 1'b0;
    end
  end

  assign wr_valid   = !w_fifo_empty;
  assign wr_data    = w_entry_out[WORD_W-1:0];
  assign wr_addr    = w_entry_out[WORD_W +: ADDR_W];
  assign wr_exp     = w_entry_out[c_ENTRY_W-1 -: 2];
  assign exposure   = r_exp;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_pixel_packer
//  Description : Self-checking bench for sdram_pixel_packer. A frame is
//                shortened to a few words so that several complete frames fit
//                in a short run. A behavioural model pushes each expected
//                word into a scoreboard queue when its final pixel is driven;
//                words are popped and compared when the DUT hands them off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_pixel_packer;

  localparam int c_FW = 6;

  logic         clk_25M = 1'b0;
  logic         rst_n_25M = 1'b0;
  logic [15:0]  pixel_in = '0;
  logic         pixel_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         err_clr = 1'b0;
  logic         wr_ready = 1'b0;
  logic [127:0] wr_data;
  logic [23:0]  wr_addr;
  logic [1:0]   wr_exp;
  logic         wr_valid;
  logic [1:0]   exposure;
  logic         frame_done;
  logic         overflow;
  logic         frame_err;

  always #20 clk_25M = ~clk_25M;

  sdram_pixel_packer #(
    .FRAME_WORDS (c_FW)
  ) dut (
    .clk_25M     (clk_25M),
    .rst_n_25M   (rst_n_25M),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .err_clr     (err_clr),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_exp      (wr_exp),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .exposure    (exposure),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [23:0]  addr;
    logic [1:0]   exp;
  } word_t;

  typedef struct {
    logic        fs;
    logic        pv;
    logic [15:0] pix;
    logic        e_valid;
  } vec_t;

  word_t       sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rx  = 0;
  int          n_fd  = 0;
  logic [23:0] last_addr [4];

  // Behavioural model (0=idle 1=active 2=done)
  int          m_st, m_lane, m_word, m_occ;
  logic [1:0]  m_exp;
  logic [15:0] m_buf [8];
  logic        m_ovf, m_ferr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] base_of(input logic [1:0] e);
    case (e)
      2'd1:    return 24'h010000;
      2'd2:    return 24'h020000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_clear();
    m_st = 0; m_lane = 0; m_word = 0; m_occ = 0;
    m_exp = 2'd0; m_ovf = 1'b0; m_ferr = 1'b0;
    for (int k = 0; k < 8; k++) m_buf[k] = '0;
    sb_q.delete();
    n_rx = 0; n_fd = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance
  // the model, then let the rising edge happen.
  task automatic step(input logic fs, input logic pv, input logic [15:0] pix, input logic clr);
    word_t        w;
    logic         pop, push, ov_set, fe_set;
    logic [127:0] d;
    frame_start = fs; pixel_valid = pv; pixel_in = pix; err_clr = clr;
    #1;
    chk("wr_valid",   wr_valid,   m_occ > 0);
    chk("frame_done", frame_done, m_st == 2);
    chk("exposure",   exposure,   m_exp);
    chk("overflow",   overflow,   m_ovf);
    chk("frame_err",  frame_err,  m_ferr);
    if (frame_done) n_fd++;
    pop = (m_occ > 0) && wr_ready;
    if (pop) begin
      n_rx++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        w = sb_q.pop_front();
        chk("wr_data", wr_data, w.data);
        chk("wr_addr", wr_addr, w.addr);
        chk("wr_exp",  wr_exp,  w.exp);
        last_addr[w.exp] = wr_addr;
      end
    end
    push = 1'b0; fe_set = 1'b0; w = '0;
    case (m_st)
      0: if (fs) begin m_st = 1; m_word = 0; m_lane = 0; end
      1: begin
        if (fs) begin
          fe_set = 1'b1; m_word = 0; m_lane = 0;
        end else if (pv) begin
          m_buf[m_lane] = pix;
          if (m_lane == 7) begin
            for (int k = 0; k < 8; k++) d[k*16 +: 16] = m_buf[k];
            w.data = d; w.addr = base_of(m_exp) + 24'(m_word); w.exp = m_exp;
            push = 1'b1; m_lane = 0;
            if (m_word == c_FW - 1) m_st = 2;
            m_word++;
          end else begin
            m_lane++;
          end
        end
      end
      default: begin
        m_exp = (m_exp == 2'd2) ? 2'd0 : m_exp + 2'd1;
        if (fs) begin m_st = 1; m_word = 0; m_lane = 0; end
        else m_st = 0;
      end
    endcase
    if (fs && pv) begin m_buf[0] = pix; m_lane = 1; end
    ov_set = 1'b0;
    if (push) begin
      if (m_occ < 2 || pop) begin sb_q.push_back(w); m_occ++; end
      else ov_set = 1'b1;
    end
    if (pop) m_occ--;
    m_ovf  = ov_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_ferr = fe_set ? 1'b1 : (clr ? 1'b0 : m_ferr);
    @(posedge clk_25M);
    @(negedge clk_25M);
  endtask

  task automatic send_pix(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n_25M = 1'b0;
    frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = '0; err_clr = 1'b0;
    @(negedge clk_25M);
    @(negedge clk_25M);
    model_clear();
    rst_n_25M = 1'b1;
    @(negedge clk_25M);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [10];
    tv[0] = '{fs: 1'b1, pv: 1'b0, pix: 16'h0, e_valid: 1'b0};
    for (int i = 1; i <= 8; i++) tv[i] = '{fs: 1'b0, pv: 1'b1, pix: 16'(i), e_valid: (i == 8)};
    tv[9] = '{fs: 1'b0, pv: 1'b0, pix: 16'h0, e_valid: 1'b0};

    // ---- 1: single word, reset state, latency -------------------------------
    wr_ready = 1'b1;
    do_reset();
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data",  wr_data, 0);
    chk("rst_wr_addr",  wr_addr, 0);
    chk("rst_exposure", exposure, 0);
    for (int i = 0; i < 10; i++) begin
      step(tv[i].fs, tv[i].pv, tv[i].pix, 1'b0);
      chk($sformatf("t1_valid_%0d", i), wr_valid, tv[i].e_valid);
      if (i == 8) begin
        chk("t1_word", wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t1_addr", wr_addr, 24'h0);
        chk("t1_exp",  wr_exp, 2'd0);
      end
    end

    // ---- 2: three frames, exposure rotation, frame_start variants ------------
    do_reset();
    wr_ready = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(8 * c_FW);
    idle(1);                                  // DONE -> IDLE
    step(1'b1, 1'b1, 16'($urandom), 1'b0);    // frame_start with lane-0 pixel
    send_pix(8 * c_FW - 1);
    step(1'b1, 1'b0, 16'h0, 1'b0);            // frame_start during DONE
    send_pix(8 * c_FW);
    idle(3);
    chk("t2_frame_done_cnt", n_fd, 3);
    chk("t2_words", n_rx, 3 * c_FW);
    chk("t2_last_high", last_addr[0], 24'h000005);
    chk("t2_last_mid",  last_addr[1], 24'h010005);
    chk("t2_last_low",  last_addr[2], 24'h020005);
    chk("t2_exposure",  exposure, 2'd0);
    chk("t2_frame_err", frame_err, 0);

    // ---- 3: backpressure, drop, address alignment ----------------------------
    do_reset();
    wr_ready = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(24);
    chk("t3_overflow", overflow, 1);
    idle(3);
    chk("t3_head_hold", wr_addr, 24'h0);
    wr_ready = 1'b1;
    idle(2);
    send_pix(8);
    chk("t3_next_addr", wr_addr, 24'h3);
    idle(1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t3_ovf_clr", overflow, 0);
    chk("t3_sb_empty", sb_q.size(), 0);

    // ---- 4: push while full with simultaneous pop ----------------------------
    do_reset();
    wr_ready = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(23);
    wr_ready = 1'b1;
    send_pix(1);
    chk("t4_no_overflow", overflow, 0);
    idle(3);
    chk("t4_words", n_rx, 3);

    // ---- 5: resync mid-word, err_clr precedence ------------------------------
    do_reset();
    wr_ready = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'h00A0 + 16'(k), 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_frame_err", frame_err, 1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'h00B0 + 16'(k), 1'b0);
    chk("t5_addr", wr_addr, 24'h0);
    chk("t5_word", wr_data, 128'h00B7_00B6_00B5_00B4_00B3_00B2_00B1_00B0);
    idle(1);
    chk("t5_exposure", exposure, 2'd0);
    step(1'b1, 1'b0, 16'h0, 1'b1);            // set and clear together
    chk("t5_set_wins", frame_err, 1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t5_clr", frame_err, 0);

    // ---- 6: async reset mid-frame --------------------------------------------
    do_reset();
    wr_ready = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(8 * c_FW);
    idle(2);
    chk("t6_exp_mid", exposure, 2'd1);
    wr_ready = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(11);
    chk("t6_queued", wr_valid, 1);
    #5;
    rst_n_25M = 1'b0;
    #1;
    chk("t6_async_valid", wr_valid, 0);
    chk("t6_async_exp",   exposure, 0);
    do_reset();
    wr_ready = 1'b1;
    send_pix(16);                             // ignored while IDLE
    step(1'b1, 1'b0, 16'h0, 1'b0);
    send_pix(8);
    chk("t6_addr", wr_addr, 24'h0);
    idle(2);
    chk("t6_words", n_rx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
